// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, data enable and
// block cursors, with frame-aligned start/stop under a level run request.
module video_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter int KH       = 30,
    parameter int KV       = 30,
    parameter bit SYNC_POL = 1'b1,
    localparam int HBLKS   = (H_WIDTH + KH - 1) / KH,
    localparam int VBLKS   = (V_HEIGHT + KV - 1) / KV,
    localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
    localparam int HTW     = (HBLKS > 1) ? $clog2(HBLKS) : 1,
    localparam int VTW     = (VBLKS > 1) ? $clog2(VBLKS) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    output logic           hs_o,
    output logic           vs_o,
    output logic           de_o,
    output logic [XW-1:0]  x_o,
    output logic [YW-1:0]  y_o,
    output logic [HTW-1:0] ht_o,
    output logic [VTW-1:0] vt_o,
    output logic           sof_o,
    output logic           busy_o
);

    localparam int HCW = (KH > 1) ? $clog2(KH) : 1;
    localparam int VCW = (KV > 1) ? $clog2(KV) : 1;

    localparam logic [XW-1:0]  X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]  X_ACTL = XW'(H_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]  Y_ACTL = YW'(V_HEIGHT - 1);
    localparam logic [HCW-1:0] HC_LAST = HCW'(KH - 1);
    localparam logic [VCW-1:0] VC_LAST = VCW'(KV - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic [HTW-1:0] ht_q, ht_d;
    logic [VTW-1:0] vt_q, vt_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           de_q, de_d;
    logic           sof_q, sof_d;
    logic           busy_q, busy_d;

    logic x_end, y_end, run_d;
    int   xi, yi;

    assign x_end = (x_q == X_LAST);
    assign y_end = (y_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        x_d     = '0;
        y_d     = '0;
        hc_d    = '0;
        vc_d    = '0;
        ht_d    = '0;
        vt_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (x_end && y_end && !en_i) begin
                    state_d = IDLE;
                end else if (x_end) begin
                    // Line wrap: horizontal cursor restarts, vertical advances.
                    if (!y_end) begin
                        y_d = y_q + 1'b1;
                        if (y_q < Y_ACTL) begin
                            if (vc_q == VC_LAST) begin
                                vt_d = vt_q + 1'b1;
                            end else begin
                                vc_d = vc_q + 1'b1;
                                vt_d = vt_q;
                            end
                        end else begin
                            vc_d = vc_q;
                            vt_d = vt_q;
                        end
                    end
                end else begin
                    x_d  = x_q + 1'b1;
                    y_d  = y_q;
                    vc_d = vc_q;
                    vt_d = vt_q;
                    if (x_q < X_ACTL) begin
                        if (hc_q == HC_LAST) begin
                            ht_d = ht_q + 1'b1;
                        end else begin
                            hc_d = hc_q + 1'b1;
                            ht_d = ht_q;
                        end
                    end else begin
                        hc_d = hc_q;
                        ht_d = ht_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flops are fed from next-state values so they track x/y exactly.
    always_comb begin
        run_d  = (state_d == RUN);
        xi     = int'(x_d);
        yi     = int'(y_d);
        busy_d = run_d;
        de_d   = run_d && (x_d <= X_ACTL) && (y_d <= Y_ACTL);
        sof_d  = run_d && (x_d == '0) && (y_d == '0);
        hs_d   = ~SYNC_POL;
        vs_d   = ~SYNC_POL;
        if (run_d && xi >= H_START && xi < H_START + H_SYNC) hs_d = SYNC_POL;
        if (run_d && yi >= V_START && yi < V_START + V_SYNC) vs_d = SYNC_POL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            ht_q    <= '0;
            vt_q    <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            de_q    <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            ht_q    <= ht_d;
            vt_q    <= vt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
        end
    end

    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign de_o   = de_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign ht_o   = ht_q;
    assign vt_o   = vt_q;
    assign sof_o  = sof_q;
    assign busy_o = busy_q;

endmodule
